// File: rtl/qspi_pkg.sv
// Shared types, constants and helpers for the QSPI memory controller.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_DESEL
    } state_e;

    typedef enum logic [1:0] {
        DEV_FLASH,
        DEV_RAM_A,
        DEV_RAM_B
    } dev_e;

    // Active-low select vectors, bit order {ram_b, ram_a, flash}
    localparam logic [2:0] SEL_NONE  = 3'b111;
    localparam logic [2:0] SEL_FLASH = 3'b110;
    localparam logic [2:0] SEL_RAM_A = 3'b101;
    localparam logic [2:0] SEL_RAM_B = 3'b011;

    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Nibble counter width; must hold READ_SKEW + 8
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] NIB_CMD   = CNT_W'(2);
    localparam logic [CNT_W-1:0] NIB_ADDR  = CNT_W'(6);
    localparam logic [CNT_W-1:0] NIB_MODE  = CNT_W'(2);
    localparam logic [CNT_W-1:0] NIB_DESEL = CNT_W'(2);

    // Top two address bits pick the device; 00 and 01 both map to flash
    function automatic dev_e decode_dev(input logic [1:0] top);
        dev_e dev;
        case (top)
            2'b10:   dev = DEV_RAM_A;
            2'b11:   dev = DEV_RAM_B;
            default: dev = DEV_FLASH;
        endcase
        return dev;
    endfunction

    function automatic logic [2:0] dev_select(input dev_e dev);
        logic [2:0] sel;
        case (dev)
            DEV_RAM_A: sel = SEL_RAM_A;
            DEV_RAM_B: sel = SEL_RAM_B;
            default:   sel = SEL_FLASH;
        endcase
        return sel;
    endfunction

    // Data-phase nibble count; the illegal length 2 behaves as a word
    function automatic logic [CNT_W-1:0] data_nibbles(input logic [1:0] len);
        logic [CNT_W-1:0] n;
        case (len)
            2'd0:    n = CNT_W'(2);
            2'd1:    n = CNT_W'(4);
            default: n = CNT_W'(8);
        endcase
        return n;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // The shift register collects byte 0 first (most significant of the
    // collected bytes); reorder into little-endian with unused bytes zero.
    function automatic logic [31:0] assemble(input logic [31:0] sr, input logic [1:0] len);
        logic [31:0] r;
        case (len)
            2'd0:    r = {24'h0, sr[7:0]};
            2'd1:    r = {16'h0, sr[7:0], sr[15:8]};
            default: r = byte_swap(sr);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qspi_nibble_shifter.sv
// 32-bit nibble shift/assemble register with a nibble counter.
// Shifting moves data toward the top nibble (the one on the bus);
// capture shifts a received nibble in at the bottom. Load clears the count.
module qspi_nibble_shifter
    import qspi_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [31:0]      load_val_i,
    input  logic             shift_i,
    input  logic             capture_i,
    input  logic [3:0]       nib_i,
    output logic [31:0]      data_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [31:0]      sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: load has priority, then capture, then plain shift
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = load_val_i;
            cnt_d = '0;
        end else if (capture_i) begin
            sr_d  = {sr_q[27:0], nib_i};
            cnt_d = cnt_q + CNT_W'(1);
        end else if (shift_i) begin
            sr_d  = {sr_q[27:0], 4'h0};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o = sr_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI master: turns CPU byte/half/word requests into flash (continuous
// read) and RAM A/B transactions. qspi_clk runs at clk/2; every bus change
// and every input sample happens in the clk cycle that drives qspi_clk 1->0.
module qspi_mem_ctrl
    import qspi_pkg::*;
#(
    parameter int         DUMMY_NIBBLES = 4,
    parameter int         READ_SKEW     = 1,
    parameter logic [7:0] MODE_BITS     = 8'hA0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [24:0] req_addr,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        qspi_clk,
    output logic [3:0]  qspi_data_out,
    output logic [3:0]  qspi_data_oe,
    input  logic [3:0]  qspi_data_in,
    output logic        qspi_flash_select,
    output logic        qspi_ram_a_select,
    output logic        qspi_ram_b_select
);

    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_NIBBLES - 1);
    localparam logic [CNT_W-1:0] SKEW_CNT   = CNT_W'(READ_SKEW);

    state_e      state_q, state_d;
    dev_e        dev_q, dev_d;
    logic [1:0]  len_q, len_d;
    logic        rd_q, rd_d;
    logic [22:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        qclk_q, qclk_d;
    logic        oe_q, oe_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;

    logic             sh_load, sh_shift, sh_capture;
    logic [31:0]      sh_val;
    logic [31:0]      sh_data;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] data_last_rd;
    logic [CNT_W-1:0] data_last_wr;
    logic [31:0]      captured;
    dev_e             req_dev;

    qspi_nibble_shifter u_shifter (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (sh_load),
        .load_val_i (sh_val),
        .shift_i    (sh_shift),
        .capture_i  (sh_capture),
        .nib_i      (qspi_data_in),
        .data_o     (sh_data),
        .cnt_o      (cnt)
    );

    assign req_dev      = decode_dev(req_addr[24:23]);
    assign data_last_wr = data_nibbles(len_q) - CNT_W'(1);
    assign data_last_rd = SKEW_CNT + data_last_wr;
    // Value the register will hold once the final read nibble is captured
    assign captured     = {sh_data[27:0], qspi_data_in};

    // Transaction sequencer: next state, shifter controls and bus outputs
    always_comb begin
        state_d    = state_q;
        dev_d      = dev_q;
        len_d      = len_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        qclk_d     = 1'b0;
        oe_d       = oe_q;
        sel_d      = sel_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        sh_load    = 1'b0;
        sh_val     = '0;
        sh_shift   = 1'b0;
        sh_capture = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                oe_d  = 1'b0;
                sel_d = SEL_NONE;
                if (req_read || req_write) begin
                    if (!req_read && req_dev == DEV_FLASH) begin
                        // Flash is read-only: reject without touching the bus
                        err_d = 1'b1;
                    end else begin
                        dev_d   = req_dev;
                        len_d   = req_len;
                        rd_d    = req_read;
                        addr_d  = req_addr[22:0];
                        wdata_d = req_wdata;
                        sel_d   = dev_select(req_dev);
                        oe_d    = 1'b1;
                        sh_load = 1'b1;
                        if (req_dev == DEV_FLASH) begin
                            // Continuous-read flash needs no command byte
                            state_d = ST_ADDR;
                            sh_val  = {1'b0, req_addr[22:0], 8'h00};
                        end else begin
                            state_d = ST_CMD;
                            sh_val  = {(req_read ? CMD_READ : CMD_WRITE), 24'h0};
                        end
                    end
                end
            end

            ST_CMD: begin
                qclk_d = ~qclk_q;
                if (qclk_q) begin
                    if (cnt == NIB_CMD - CNT_W'(1)) begin
                        state_d = ST_ADDR;
                        sh_load = 1'b1;
                        sh_val  = {1'b0, addr_q, 8'h00};
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end

            ST_ADDR: begin
                qclk_d = ~qclk_q;
                if (qclk_q) begin
                    if (cnt == NIB_ADDR - CNT_W'(1)) begin
                        sh_load = 1'b1;
                        if (dev_q == DEV_FLASH) begin
                            state_d = ST_MODE;
                            sh_val  = {MODE_BITS, 24'h0};
                        end else if (rd_q) begin
                            state_d = ST_DUMMY;
                            oe_d    = 1'b0;
                        end else begin
                            // Byte 0 moves to the top so it leaves first
                            state_d = ST_DATA;
                            sh_val  = byte_swap(wdata_q);
                        end
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end

            ST_MODE: begin
                qclk_d = ~qclk_q;
                if (qclk_q) begin
                    if (cnt == NIB_MODE - CNT_W'(1)) begin
                        state_d = ST_DUMMY;
                        oe_d    = 1'b0;
                        sh_load = 1'b1;
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end

            ST_DUMMY: begin
                qclk_d = ~qclk_q;
                if (qclk_q) begin
                    if (cnt == DUMMY_LAST) begin
                        // Clears the register so read bytes assemble from zero
                        state_d = ST_DATA;
                        sh_load = 1'b1;
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                qclk_d = ~qclk_q;
                if (qclk_q) begin
                    if (rd_q) begin
                        if (cnt < SKEW_CNT) begin
                            // Skew periods shift zeros, keeping the register clean
                            sh_shift = 1'b1;
                        end else if (cnt == data_last_rd) begin
                            state_d  = ST_DESEL;
                            sel_d    = SEL_NONE;
                            rvalid_d = 1'b1;
                            rdata_d  = assemble(captured, len_q);
                            sh_load  = 1'b1;
                        end else begin
                            sh_capture = 1'b1;
                        end
                    end else begin
                        if (cnt == data_last_wr) begin
                            state_d = ST_DESEL;
                            sel_d   = SEL_NONE;
                            oe_d    = 1'b0;
                            sh_load = 1'b1;
                        end else begin
                            sh_shift = 1'b1;
                        end
                    end
                end
            end

            ST_DESEL: begin
                // Hold CS high for the minimum deselect time
                sel_d = SEL_NONE;
                oe_d  = 1'b0;
                if (cnt == NIB_DESEL - CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    sh_shift = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_NONE;
                oe_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            dev_q    <= DEV_FLASH;
            len_q    <= 2'd0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            qclk_q   <= 1'b0;
            oe_q     <= 1'b0;
            sel_q    <= SEL_NONE;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dev_q    <= dev_d;
            len_q    <= len_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            qclk_q   <= qclk_d;
            oe_q     <= oe_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign ready             = (state_q == ST_IDLE);
    assign rdata             = rdata_q;
    assign rdata_valid       = rvalid_q;
    assign err               = err_q;
    assign qspi_clk          = qclk_q;
    assign qspi_data_oe      = {4{oe_q}};
    assign qspi_data_out     = oe_q ? sh_data[31:28] : 4'h0;
    assign qspi_flash_select = sel_q[0];
    assign qspi_ram_a_select = sel_q[1];
    assign qspi_ram_b_select = sel_q[2];

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Directed bench for qspi_mem_ctrl with a simple bus monitor / memory model.
module tb_qspi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [24:0] req_addr = '0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_len = '0;
    logic [31:0] req_wdata = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        qspi_clk;
    logic [3:0]  qspi_data_out;
    logic [3:0]  qspi_data_oe;
    logic [3:0]  qspi_data_in = 4'h0;
    logic        qspi_flash_select;
    logic        qspi_ram_a_select;
    logic        qspi_ram_b_select;

    qspi_mem_ctrl #(
        .DUMMY_NIBBLES (4),
        .READ_SKEW     (1),
        .MODE_BITS     (8'hA0)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .req_addr          (req_addr),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_len           (req_len),
        .req_wdata         (req_wdata),
        .ready             (ready),
        .rdata             (rdata),
        .rdata_valid       (rdata_valid),
        .err               (err),
        .qspi_clk          (qspi_clk),
        .qspi_data_out     (qspi_data_out),
        .qspi_data_oe      (qspi_data_oe),
        .qspi_data_in      (qspi_data_in),
        .qspi_flash_select (qspi_flash_select),
        .qspi_ram_a_select (qspi_ram_a_select),
        .qspi_ram_b_select (qspi_ram_b_select)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor / memory model: 12 pre-data periods, 1 skew, data from edge 14
    localparam int FIRST_DATA = 14;

    logic [3:0] drv_q[$];
    logic [7:0] rd_bytes[4];
    int  edges = 0, last_edges = 0, rv_cnt = 0, err_cnt = 0;
    int  gap_viol = 0, hi_run = 100, oe_bad = 0;
    int  flash_low = 0, ram_a_low = 0, ram_b_low = 0;
    bit  prev_qclk = 1'b0;

    always @(negedge clk) begin
        int idx;
        if (rdata_valid) rv_cnt++;
        if (err) err_cnt++;
        if (qspi_data_oe != 4'h0 && qspi_data_oe != 4'hF) oe_bad++;
        if (!qspi_flash_select) flash_low++;
        if (!qspi_ram_a_select) ram_a_low++;
        if (!qspi_ram_b_select) ram_b_low++;
        if (qspi_flash_select && qspi_ram_a_select && qspi_ram_b_select) begin
            if (edges != 0) last_edges = edges;
            edges = 0;
            hi_run++;
        end else begin
            if (hi_run > 0 && hi_run < 2) gap_viol++;
            hi_run = 0;
            if (qspi_clk && !prev_qclk) begin
                edges++;
                if (qspi_data_oe == 4'hF) drv_q.push_back(qspi_data_out);
                idx = edges - FIRST_DATA;
                if (idx >= 0 && idx < 8)
                    qspi_data_in = idx[0] ? rd_bytes[idx / 2][3:0] : rd_bytes[idx / 2][7:4];
                else
                    qspi_data_in = 4'hF;
            end
        end
        prev_qclk = qspi_clk;
    end

    task automatic issue(input logic [24:0] a, input bit rd, input bit wr,
                         input logic [1:0] len, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", {31'h0, ready}, 32'h1);
        req_addr  = a;
        req_read  = rd;
        req_write = wr;
        req_len   = len;
        req_wdata = wd;
        @(negedge clk);
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("done_timeout", {31'h0, ready}, 32'h1);
        @(negedge clk);
        #2;
    endtask

    task automatic check_nibs(input string tag, input int s0, input logic [63:0] exp, input int n);
        check({tag, "_count"}, drv_q.size() - s0, n);
        for (int i = 0; i < n; i++)
            if (s0 + i < drv_q.size())
                check($sformatf("%s_nib%0d", tag, i), {28'h0, drv_q[s0 + i]}, {28'h0, exp[4*(n-1-i) +: 4]});
    endtask

    initial begin
        int s0, rv0, e0, f0, a0, b0, n;
        logic [7:0] wbyte;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_sel", {29'h0, qspi_ram_b_select, qspi_ram_a_select, qspi_flash_select}, 32'h7);
        check("rst_qclk", {31'h0, qspi_clk}, 32'h0);
        check("rst_oe", {28'h0, qspi_data_oe}, 32'h0);
        check("rst_dout", {28'h0, qspi_data_out}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", {31'h0, rdata_valid}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #2;

        // 1: flash word read
        rd_bytes = '{8'h13, 8'h37, 8'hC0, 8'hDE};
        s0 = drv_q.size(); rv0 = rv_cnt; e0 = err_cnt; f0 = flash_low;
        issue(25'h0000100, 1'b1, 1'b0, 2'd3, 32'h0);
        wait_idle();
        $display("txn flash read  addr=0000100 len=3 rdata=%h", rdata);
        check("t1_rdata", rdata, 32'hDEC03713);
        check("t1_valid", rv_cnt - rv0, 1);
        check("t1_err", err_cnt - e0, 0);
        check("t1_edges", last_edges, 21);
        check("t1_flash_sel", {31'h0, (flash_low > f0)}, 32'h1);
        check_nibs("t1", s0, 64'h000100A0, 8);

        // 2: RAM A byte write then read back
        s0 = drv_q.size(); rv0 = rv_cnt; a0 = ram_a_low; f0 = flash_low;
        issue(25'h1000020, 1'b0, 1'b1, 2'd0, 32'h0000005A);
        wait_idle();
        $display("txn ramA write  addr=1000020 len=0 wdata=0000005a");
        check_nibs("t2w", s0, 64'h020000205A, 10);
        check("t2w_edges", last_edges, 10);
        check("t2w_valid", rv_cnt - rv0, 0);
        check("t2w_ram_a_sel", {31'h0, (ram_a_low > a0)}, 32'h1);
        check("t2w_flash_sel", flash_low - f0, 0);
        wbyte = 8'h00;
        if (drv_q.size() >= s0 + 10) wbyte = {drv_q[s0 + 8], drv_q[s0 + 9]};
        rd_bytes = '{wbyte, 8'h77, 8'h88, 8'h99};
        s0 = drv_q.size(); rv0 = rv_cnt;
        issue(25'h1000020, 1'b1, 1'b0, 2'd0, 32'h0);
        wait_idle();
        $display("txn ramA read   addr=1000020 len=0 rdata=%h", rdata);
        check("t2r_rdata", rdata, 32'h0000005A);
        check("t2r_valid", rv_cnt - rv0, 1);
        check("t2r_edges", last_edges, 15);
        check_nibs("t2r", s0, 64'h0B000020, 8);

        // 3: RAM B halfword write then read; bit 23 of the address forced low
        s0 = drv_q.size(); a0 = ram_a_low; f0 = flash_low; b0 = ram_b_low;
        issue(25'h1800004, 1'b0, 1'b1, 2'd1, 32'h0000BEEF);
        wait_idle();
        $display("txn ramB write  addr=1800004 len=1 wdata=0000beef");
        check_nibs("t3w", s0, 64'h02000004EFBE, 12);
        check("t3w_edges", last_edges, 12);
        rd_bytes = '{8'hEF, 8'hBE, 8'h11, 8'h22};
        s0 = drv_q.size(); rv0 = rv_cnt;
        issue(25'h1800004, 1'b1, 1'b0, 2'd1, 32'h0);
        wait_idle();
        $display("txn ramB read   addr=1800004 len=1 rdata=%h", rdata);
        check("t3r_rdata", rdata, 32'h0000BEEF);
        check("t3r_edges", last_edges, 17);
        check_nibs("t3r", s0, 64'h0B000004, 8);
        check("t3_ram_a_sel", ram_a_low - a0, 0);
        check("t3_flash_sel", flash_low - f0, 0);
        check("t3_ram_b_sel", {31'h0, (ram_b_low > b0)}, 32'h1);

        // 4: flash write is rejected
        s0 = drv_q.size(); e0 = err_cnt; f0 = flash_low; a0 = ram_a_low; b0 = ram_b_low;
        issue(25'h0000010, 1'b0, 1'b1, 2'd0, 32'h00000055);
        check("t4_ready_now", {31'h0, ready}, 32'h1);
        repeat (4) @(negedge clk);
        #2;
        $display("txn flash write addr=0000010 rejected err_pulses=%0d", err_cnt - e0);
        check("t4_err", err_cnt - e0, 1);
        check("t4_ready", {31'h0, ready}, 32'h1);
        check("t4_sel", (flash_low - f0) + (ram_a_low - a0) + (ram_b_low - b0), 0);
        check("t4_bus", drv_q.size() - s0, 0);

        // 5: reset in the middle of a word read's data phase
        rd_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rv0 = rv_cnt;
        issue(25'h1000040, 1'b1, 1'b0, 2'd3, 32'h0);
        n = 0;
        while (edges < 16 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_data", {31'h0, (edges >= 16)}, 32'h1);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        check("t5_sel", {29'h0, qspi_ram_b_select, qspi_ram_a_select, qspi_flash_select}, 32'h7);
        check("t5_oe", {28'h0, qspi_data_oe}, 32'h0);
        check("t5_ready", {31'h0, ready}, 32'h1);
        check("t5_qclk", {31'h0, qspi_clk}, 32'h0);
        check("t5_rdata", rdata, 32'h0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        $display("txn ramA read   addr=1000040 len=3 aborted by reset");
        check("t5_no_valid", rv_cnt - rv0, 0);
        rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        s0 = drv_q.size(); rv0 = rv_cnt;
        issue(25'h0812345, 1'b1, 1'b0, 2'd3, 32'h0);
        wait_idle();
        $display("txn flash read  addr=0812345 len=3 rdata=%h", rdata);
        check("t5r_rdata", rdata, 32'h44332211);
        check("t5r_valid", rv_cnt - rv0, 1);
        check_nibs("t5r", s0, 64'h012345A0, 8);

        // Illegal length 2 behaves as a word
        rd_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        issue(25'h0000004, 1'b1, 1'b0, 2'd2, 32'h0);
        wait_idle();
        $display("txn flash read  addr=0000004 len=2 rdata=%h", rdata);
        check("len2_rdata", rdata, 32'h04030201);
        check("len2_edges", last_edges, 21);

        // 6: read wins over write; then back-to-back requests
        rd_bytes = '{8'hA5, 8'h5A, 8'h00, 8'h00};
        s0 = drv_q.size(); rv0 = rv_cnt;
        issue(25'h1800004, 1'b1, 1'b1, 2'd1, 32'h12345678);
        wait_idle();
        $display("txn ramB r+w    addr=1800004 len=1 rdata=%h", rdata);
        check("t6_rdata", rdata, 32'h00005AA5);
        check_nibs("t6", s0, 64'h0B000004, 8);
        rv0 = rv_cnt;
        issue(25'h0000000, 1'b1, 1'b0, 2'd3, 32'h0);
        issue(25'h1800000, 1'b1, 1'b0, 2'd0, 32'h0);
        wait_idle();
        $display("txn back2back   flash word + ramB byte rdata=%h", rdata);
        check("t6_b2b_valid", rv_cnt - rv0, 2);
        check("t6_b2b_rdata", rdata, 32'h000000A5);

        check("gap_violations", gap_viol, 0);
        check("oe_split", oe_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
